// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: function codes, FSM encoding, default width.
package exec_pkg;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_AND = 2'b10;
  localparam logic [1:0] FN_MUL = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per clock after start.
// done and product are combinational on the final step so the caller can register them.
module shift_add_mul
  import exec_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MUL_STEPS = DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);
  localparam int RW = 2 * DATA_W;
  localparam int CW = $clog2(MUL_STEPS + 1);

  logic              active_q, active_d;
  logic [CW-1:0]     count_q, count_d;
  logic [RW-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     acc_step;

  // Multiplicand walks left while the multiplier walks right, so each step only looks at bit 0.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = active_q && (count_q == CW'(MUL_STEPS - 1));
  assign product  = acc_step;

  always_comb begin
    active_d = active_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      active_d = 1'b1;
      count_d  = '0;
      mcand_d  = RW'(a);
      mplier_d = b;
      acc_d    = '0;
    end else if (active_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 1'b1;
      if (done) begin
        active_d = 1'b0;
        count_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      active_q <= active_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end
endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ADD/SUB/AND, multi-cycle MUL that stalls upstream.
// Define EXECUTE_FAST_MUL_EN to make MUL a single-cycle combinational multiply.
module execute_stage
  import exec_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MUL_STEPS = DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic [DATA_W-1:0]   op1,
  input  logic [DATA_W-1:0]   op2,
  input  logic [1:0]          fn,
  output logic                stall,
  output logic                out_valid,
  output logic [DATA_W-1:0]   pc_out,
  output logic [2*DATA_W-1:0] result,
  output logic                zero,
  output logic                carry
);
  localparam int RW = 2 * DATA_W;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] pc_out_q, pc_out_d;
  logic [RW-1:0]     result_q, result_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] and_v;
  logic [RW-1:0]     alu_res;
  logic              alu_carry;

  assign sum   = {1'b0, op1} + {1'b0, op2};
  assign diff  = op1 - op2;
  assign and_v = op1 & op2;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (fn)
      FN_ADD: begin
        alu_res   = RW'(sum);
        alu_carry = sum[DATA_W];
      end
      FN_SUB: begin
        alu_res   = RW'(diff);
        alu_carry = (op1 < op2);
      end
      FN_AND: begin
        alu_res   = RW'(and_v);
        alu_carry = 1'b0;
      end
      default: begin
`ifdef EXECUTE_FAST_MUL_EN
        alu_res   = RW'(op1) * RW'(op2);
        alu_carry = |alu_res[RW-1:DATA_W];
`else
        alu_res   = '0;
        alu_carry = 1'b0;
`endif
      end
    endcase
  end

`ifndef EXECUTE_FAST_MUL_EN
  logic              mul_start;
  logic              mul_done;
  logic [RW-1:0]     mul_product;
  logic [DATA_W-1:0] mul_pc_q, mul_pc_d;

  shift_add_mul #(
    .DATA_W    (DATA_W),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op1),
    .b       (op2),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    pc_out_d    = pc_out_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
`ifndef EXECUTE_FAST_MUL_EN
    mul_start   = 1'b0;
    mul_pc_d    = mul_pc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifndef EXECUTE_FAST_MUL_EN
          if (fn == FN_MUL) begin
            mul_start = 1'b1;
            mul_pc_d  = pc_in;
            state_d   = BUSY;
          end else
`endif
          begin
            out_valid_d = 1'b1;
            pc_out_d    = pc_in;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_carry;
          end
        end
      end
      default: begin
`ifndef EXECUTE_FAST_MUL_EN
        // Inputs are ignored here; upstream keeps presenting the next instruction until stall drops.
        if (mul_done) begin
          out_valid_d = 1'b1;
          pc_out_d    = mul_pc_q;
          result_d    = mul_product;
          zero_d      = (mul_product == '0);
          carry_d     = |mul_product[RW-1:DATA_W];
          state_d     = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      pc_out_q    <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      pc_out_q    <= pc_out_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
    end
  end

`ifndef EXECUTE_FAST_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) mul_pc_q <= '0;
    else     mul_pc_q <= mul_pc_d;
  end
`endif

  assign stall     = (state_q == BUSY);
  assign out_valid = out_valid_q;
  assign pc_out    = pc_out_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized checks of execute_stage against an arithmetic reference model.
module tb_execute_stage;
  localparam int DATA_W    = 8;
  localparam int MUL_STEPS = 8;
`ifdef EXECUTE_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = MUL_STEPS + 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] pc_in, op1, op2;
  logic [1:0]        fn;
  logic              stall, out_valid, zero, carry;
  logic [DATA_W-1:0] pc_out;
  logic [2*DATA_W-1:0] result;

  int checks = 0;
  int errors = 0;

  execute_stage #(.DATA_W(DATA_W), .MUL_STEPS(MUL_STEPS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in), .op1(op1), .op2(op2),
    .fn(fn), .stall(stall), .out_valid(out_valid), .pc_out(pc_out), .result(result),
    .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the op definitions.
  function automatic void model(input int f, input int a, input int b,
                                output int r, output int c);
    case (f)
      0: begin r = a + b; c = (r > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: begin r = a & b; c = 0; end
      default: begin r = a * b; c = (r > 255) ? 1 : 0; end
    endcase
  endfunction

  function automatic int pick();
    int s = $urandom_range(0, 7);
    if (s == 0) return 0;
    if (s == 1) return 255;
    return $urandom_range(0, 255);
  endfunction

  // Presents one instruction for a single accept edge and waits (bounded) for its result.
  task automatic run_op(input string tag, input int f, input int a, input int b, input int pc);
    int r, c, lat, sc;
    model(f, a, b, r, c);
    @(negedge clk);
    in_valid = 1'b1; fn = 2'(f); op1 = 8'(a); op2 = 8'(b); pc_in = 8'(pc);
    @(posedge clk); #1;
    lat = 1;
    sc  = stall ? 1 : 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (stall) sc++;
    end
    check({tag, ".out_valid"}, 32'(out_valid), 1);
    check({tag, ".latency"}, lat, (f == 3) ? MUL_LAT : 1);
    check({tag, ".stall_cycles"}, sc, (f == 3) ? MUL_LAT - 1 : 0);
    check({tag, ".result"}, result, r);
    check({tag, ".carry"}, 32'(carry), c);
    check({tag, ".zero"}, 32'(zero), (r == 0) ? 1 : 0);
    check({tag, ".pc_out"}, pc_out, pc);
  endtask

  initial begin
    int lat, sc;
    rst = 1'b1; in_valid = 1'b0; pc_in = '0; op1 = '0; op2 = '0; fn = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.stall", 32'(stall), 0);
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.result", result, 0);
    check("rst.pc_out", pc_out, 0);
    check("rst.zero", 32'(zero), 0);
    check("rst.carry", 32'(carry), 0);
    @(negedge clk); rst = 1'b0;

    run_op("add200_100", 0, 200, 100, 8'h11);
    check("add.result_const", result, 16'h012C);
    run_op("sub5_5", 1, 5, 5, 8'h12);
    run_op("sub3_5", 1, 3, 5, 8'h13);
    check("sub3_5.result_const", result, 16'h00FE);
    run_op("and_f0_0f", 2, 8'hF0, 8'h0F, 8'h14);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle.out_valid", 32'(out_valid), 0);
      check("idle.result", result, 0);
      check("idle.zero", 32'(zero), 1);
    end

    // MUL 255*255 with a different ADD held by upstream while stalled.
    @(negedge clk);
    in_valid = 1'b1; fn = 2'd3; op1 = 8'd255; op2 = 8'd255; pc_in = 8'h20;
    @(posedge clk); #1;
    lat = 1;
    sc  = stall ? 1 : 0;
    check("mulheld.first_out_valid", 32'(out_valid), (MUL_LAT == 1) ? 1 : 0);
    @(negedge clk);
    fn = 2'd0; op1 = 8'd7; op2 = 8'd9; pc_in = 8'h42;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (stall) sc++;
    end
    check("mulheld.stall_cycles", sc, MUL_LAT - 1);
    check("mulheld.result", result, 16'hFE01);
    check("mulheld.carry", 32'(carry), 1);
    check("mulheld.pc_out", pc_out, 8'h20);
    check("mulheld.stall_at_valid", 32'(stall), 0);
    @(posedge clk); #1;
    check("heldadd.out_valid", 32'(out_valid), 1);
    check("heldadd.result", result, 16);
    check("heldadd.pc_out", pc_out, 8'h42);
    @(negedge clk); in_valid = 1'b0;

    // Reset four edges into a multiply.
    @(negedge clk);
    in_valid = 1'b1; fn = 2'd3; op1 = 8'd12; op2 = 8'd13; pc_in = 8'h30;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.stall", 32'(stall), 0);
    check("midrst.out_valid", 32'(out_valid), 0);
    check("midrst.result", result, 0);
    check("midrst.pc_out", pc_out, 0);
    check("midrst.carry", 32'(carry), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("midrst.idle_stall", 32'(stall), 0);
    run_op("mul12_13", 3, 12, 13, 8'h31);
    check("mul12_13.result_const", result, 16'h009C);
    run_op("mul16_16", 3, 16, 16, 8'h32);
    check("mul16_16.result_const", result, 16'h0100);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", $urandom_range(0, 3), pick(), pick(), $urandom_range(0, 255));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 8-bit pipelined processor, directly downstream of the Decode stage.
- Consumes pc, op1, op2 and fn from Decode and computes the ALU result and flags into a registered EX/WB output.
- ADD, SUB and AND complete in 1 cycle.
- MUL is a multi-cycle shift-add; during it `stall` is raised back to Decode/Fetch to freeze the pipeline.

Parameters:
- DATA_W, 8, operand width; the result is 2*DATA_W.
- MUL_STEPS, DATA_W, number of shift-add iterations for MUL.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  Decode outputs are valid this cycle.
- pc_in  input  DATA_W  PC of the instruction from Decode.
- op1  input  DATA_W  first operand.
- op2  input  DATA_W  second operand.
- fn  input  2  function: 00 ADD, 01 SUB, 10 AND, 11 MUL.
- stall  output  1  high while a MUL is in progress; upstream holds its outputs.
- out_valid  output  1  one-cycle pulse marking a new result.
- pc_out  output  DATA_W  PC of the completed instruction.
- result  output  2*DATA_W  ALU result, zero-extended where narrower.
- zero  output  1  high when result == 0.
- carry  output  1  carry / borrow / overflow flag.

Behaviour:
- Reset: only clk and synchronous active-high rst; no other clock or reset.
  - On rst=1 at a rising edge: state=IDLE, stall=0, out_valid=0, pc_out=0, result=0, zero=0 (explicitly cleared, not derived), carry=0.
  - rst takes priority over everything, including mid-MUL; the partial product is discarded.
- States: IDLE, BUSY.
  - stall = (state==BUSY), purely registered-state driven; it never depends combinationally on the inputs.
- IDLE, in_valid=1, fn!=11, at edge N: result, flags and pc_out are registered; out_valid=1 for the cycle after edge N (latency 1).
- Arithmetic:
  - ADD: result = zero-extended {carry, op1+op2} (9 bits); carry = bit DATA_W of the sum.
  - SUB: result = zero-extended (op1-op2) mod 2^DATA_W; carry = 1 iff op1 < op2 (borrow).
  - AND: result = zero-extended op1&op2; carry = 0.
  - MUL: result = full 2*DATA_W unsigned product; carry = |result[2*DATA_W-1:DATA_W].
  - zero is computed on the final registered result for every op.
- MUL accepted at edge N (IDLE, in_valid=1, fn=11):
  - At edge N: latch op1/op2/pc_in, clear the accumulator, count=0, state=BUSY. out_valid=0 after this edge.
  - Edges N+1..N+MUL_STEPS: one shift-add step each.
  - At edge N+MUL_STEPS: result, flags and pc_out are registered, out_valid=1, state=IDLE.
  - stall is high for exactly MUL_STEPS cycles.
- While BUSY: in_valid/op1/op2/fn are ignored. Upstream holds them, but they are not consumed; the held instruction is re-accepted when stall falls.
- In the cycle out_valid pulses, stall=0, so a new instruction may be accepted at the next edge (back-to-back MULs: 1 accept cycle + MUL_STEPS busy).
- in_valid=0 in IDLE: out_valid=0; result, pc_out and flags hold their previous values.
- count wraps only via the state transition; there is no free-running counter.

Optional Feature:
- Macro: EXECUTE_FAST_MUL_EN.
- Defined: MUL uses a combinational DATA_W x DATA_W multiplier and completes in 1 cycle like the other ops. BUSY is unused, stall is tied to 0, and the shift-add sub-module is not instantiated.
- Undefined: the multi-cycle behaviour above.

Decomposition:
- Shared package exec_pkg:
  - fn codes FN_ADD=2'b00, FN_SUB=2'b01, FN_AND=2'b10, FN_MUL=2'b11.
  - state encoding IDLE/BUSY.
  - default DATA_W.
- Sub-module: shift_add_mul. Interface: start, operands, done, product; owns the accumulator and step counter. execute_stage wraps it with the FSM, the single-cycle ALU and the output registers.

Test Plan:
- ADD op1=200, op2=100, in_valid=1 -> next cycle out_valid=1, result=0x012C, carry=1, zero=0, pc_out=pc_in.
- SUB 5-5 -> result=0x0000, zero=1, carry=0; then SUB 3-5 -> result=0x00FE, carry=1, zero=0.
- AND 0xF0&0x0F -> result=0, zero=1, carry=0; then in_valid=0 for 3 cycles -> out_valid=0, result held at 0.
- MUL 255*255 at edge N -> stall=1 for 8 cycles; out_valid=1 after edge N+8 with result=0xFE01, carry=1. A changed ADD presented with in_valid=1 during stall is ignored until stall falls.
- Reset mid-multiply: MUL 12*13, rst=1 at edge N+4 -> after that edge stall=0, out_valid=0, result=0, state IDLE. After release, MUL 12*13 -> result=0x009C, carry=0.
- With EXECUTE_FAST_MUL_EN: MUL 16*16 -> out_valid next cycle, result=0x0100, carry=1, stall never asserted.
